// File: rtl/sweep_scheduler_pkg.sv
// rtl/sweep_scheduler_pkg.sv - shared types and grid defaults for the sweep scheduler
package sweep_scheduler_pkg;

    // Existing coordinate widths of the environment grid
    localparam int X_bits = 8;
    localparam int Y_bits = 7;

    // Default grid extent (inclusive last indices)
    localparam int GRID_X_MAX = 159;
    localparam int GRID_Y_MAX = 119;

    // Sweep trigger modes; 2'b11 is not listed and behaves like PAUSE
    typedef enum logic [1:0] {
        FREE  = 2'b00,
        PAUSE = 2'b01,
        STEP  = 2'b10
    } sweep_mode_t;

    // Scheduler states
    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DRAIN,
        DONE
    } sweep_state_t;

endpackage

// File: rtl/sweep_scheduler_loc_delay_line.sv
// rtl/sweep_scheduler_loc_delay_line.sv - fixed-depth delay line carrying {x, y, lane mask}
module loc_delay_line
    import sweep_scheduler_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    // Shift register; clr flushes every stage in one cycle so an aborted sweep leaves no writes behind
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/sweep_scheduler.sv
// rtl/sweep_scheduler.sv - raster sweep sequencer issuing view and delayed write coordinates
module sweep_scheduler
    import sweep_scheduler_pkg::*;
#(
    parameter int X_BITS  = X_bits,
    parameter int Y_BITS  = Y_bits,
    parameter int X_MAX   = GRID_X_MAX,
    parameter int Y_MAX   = GRID_Y_MAX,
    parameter int LANES   = 1,
    parameter int LATENCY = 2
) (
    input  logic              newLocClock,
    input  logic              RESET_SIM,
    input  logic              RUN,
    input  logic              game_tick,
    input  logic [1:0]        mode,
    input  logic              step_req,
    output logic [X_BITS-1:0] viewLoc_x,
    output logic [Y_BITS-1:0] viewLoc_y,
    output logic [LANES-1:0]  view_valid,
    output logic [X_BITS-1:0] writeLoc_x,
    output logic [Y_BITS-1:0] writeLoc_y,
    output logic [LANES-1:0]  write_flag,
    output logic              sweep_busy,
    output logic              sweep_done,
    output logic [15:0]       frame_count,
    output logic [7:0]        overrun_count
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int DL_W  = X_BITS + Y_BITS + LANES;

    // One extra bit on coordinate math so x+LANES and y+1 never wrap
    localparam logic [X_BITS:0]    X_LAST   = (X_BITS+1)'(X_MAX);
    localparam logic [Y_BITS:0]    Y_LAST   = (Y_BITS+1)'(Y_MAX);
    localparam logic [X_BITS:0]    X_STEP   = (X_BITS+1)'(LANES);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(LATENCY - 1);

    sweep_state_t      state;
    logic [CNT_W-1:0]  drain_cnt;
    logic [X_BITS:0]   x_adv;
    logic [Y_BITS:0]   y_adv;
    logic              row_end;
    logic              last_row;
    logic [X_BITS-1:0] next_x;
    logic [Y_BITS-1:0] next_y;
    logic [LANES-1:0]  next_mask;
    logic [LANES-1:0]  first_mask;
    logic              trigger;
    logic              overrun_tick;
    logic              abort;
    logic [DL_W-1:0]   write_bus;

    // Lane i of a group based at x is live only while x+i stays on the grid
    function automatic logic [LANES-1:0] lane_mask(input logic [X_BITS-1:0] x);
        logic [LANES-1:0] m;
        m = '0;
        for (int i = 0; i < LANES; i++)
            m[i] = (({1'b0, x} + (X_BITS+1)'(i)) <= X_LAST);
        return m;
    endfunction

    // Next raster group, trigger decode and abort detection
    always_comb begin
        x_adv        = {1'b0, viewLoc_x} + X_STEP;
        y_adv        = {1'b0, viewLoc_y} + 1'b1;
        row_end      = (x_adv > X_LAST);
        last_row     = (y_adv > Y_LAST);
        next_x       = row_end ? '0 : x_adv[X_BITS-1:0];
        next_y       = row_end ? y_adv[Y_BITS-1:0] : viewLoc_y;
        next_mask    = lane_mask(next_x);
        first_mask   = lane_mask('0);
        overrun_tick = RUN && (mode == FREE) && game_tick;
        trigger      = overrun_tick || (RUN && (mode == STEP) && step_req);
        abort        = !RUN && (state != IDLE);
    end

    // Sweep FSM with registered view coordinates, status and counters
    always_ff @(posedge newLocClock or posedge RESET_SIM) begin
        if (RESET_SIM) begin
            state         <= IDLE;
            drain_cnt     <= '0;
            viewLoc_x     <= '0;
            viewLoc_y     <= '0;
            view_valid    <= '0;
            sweep_busy    <= 1'b0;
            sweep_done    <= 1'b0;
            frame_count   <= '0;
            overrun_count <= '0;
        end else begin
            sweep_done <= 1'b0;
            if (abort) begin
                state      <= IDLE;
                drain_cnt  <= '0;
                viewLoc_x  <= '0;
                viewLoc_y  <= '0;
                view_valid <= '0;
                sweep_busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (trigger) begin
                            state      <= SWEEP;
                            viewLoc_x  <= '0;
                            viewLoc_y  <= '0;
                            view_valid <= first_mask;
                            sweep_busy <= 1'b1;
                        end
                    end
                    SWEEP: begin
                        if (overrun_tick && overrun_count != 8'hFF)
                            overrun_count <= overrun_count + 8'd1;
                        if (row_end && last_row) begin
                            state      <= DRAIN;
                            drain_cnt  <= '0;
                            viewLoc_x  <= '0;
                            viewLoc_y  <= '0;
                            view_valid <= '0;
                        end else begin
                            viewLoc_x  <= next_x;
                            viewLoc_y  <= next_y;
                            view_valid <= next_mask;
                        end
                    end
                    DRAIN: begin
                        if (overrun_tick && overrun_count != 8'hFF)
                            overrun_count <= overrun_count + 8'd1;
                        if (drain_cnt == CNT_LAST) begin
                            state       <= DONE;
                            sweep_done  <= 1'b1;
                            frame_count <= frame_count + 16'd1;
                        end else begin
                            drain_cnt <= drain_cnt + 1'b1;
                        end
                    end
                    DONE: begin
                        // A trigger on the edge closing DONE starts the next frame back to back
                        if (trigger) begin
                            state      <= SWEEP;
                            viewLoc_x  <= '0;
                            viewLoc_y  <= '0;
                            view_valid <= first_mask;
                        end else begin
                            state      <= IDLE;
                            sweep_busy <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    loc_delay_line #(
        .WIDTH (DL_W),
        .DEPTH (LATENCY)
    ) u_delay (
        .clk  (newLocClock),
        .rst  (RESET_SIM),
        .clr  (abort),
        .din  ({viewLoc_x, viewLoc_y, view_valid}),
        .dout (write_bus)
    );

    assign {writeLoc_x, writeLoc_y, write_flag} = write_bus;

endmodule

// File: tb/tb_sweep_scheduler.sv
// tb/tb_sweep_scheduler.sv - self-checking bench for sweep_scheduler on two grid shapes
module tb_sweep_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       tick;
    logic [1:0] mode;
    logic       step_req;

    logic [7:0]  a_vx, a_wx, b_vx, b_wx;
    logic [6:0]  a_vy, a_wy, b_vy, b_wy;
    logic [0:0]  a_vv, a_wf;
    logic [1:0]  b_vv, b_wf;
    logic        a_busy, a_done, b_busy, b_done;
    logic [15:0] a_frm, b_frm;
    logic [7:0]  a_ovr, b_ovr;

    logic [7:0]  o_vx [2];
    logic [6:0]  o_vy [2];
    logic [1:0]  o_vv [2];
    logic [7:0]  o_wx [2];
    logic [6:0]  o_wy [2];
    logic [1:0]  o_wf [2];
    logic        o_busy [2];
    logic        o_done [2];
    logic [15:0] o_frm [2];
    logic [7:0]  o_ovr [2];

    int vectors = 0;
    int miscompares = 0;

    bit act [2];
    int d [2];
    int frames [2];
    int ovr [2];

    always #5 clk = ~clk;

    sweep_scheduler #(.X_BITS(8), .Y_BITS(7), .X_MAX(3), .Y_MAX(1), .LANES(1), .LATENCY(2)) dut_a (
        .newLocClock(clk), .RESET_SIM(rst), .RUN(run), .game_tick(tick), .mode(mode), .step_req(step_req),
        .viewLoc_x(a_vx), .viewLoc_y(a_vy), .view_valid(a_vv),
        .writeLoc_x(a_wx), .writeLoc_y(a_wy), .write_flag(a_wf),
        .sweep_busy(a_busy), .sweep_done(a_done), .frame_count(a_frm), .overrun_count(a_ovr)
    );

    sweep_scheduler #(.X_BITS(8), .Y_BITS(7), .X_MAX(4), .Y_MAX(0), .LANES(2), .LATENCY(2)) dut_b (
        .newLocClock(clk), .RESET_SIM(rst), .RUN(run), .game_tick(tick), .mode(mode), .step_req(step_req),
        .viewLoc_x(b_vx), .viewLoc_y(b_vy), .view_valid(b_vv),
        .writeLoc_x(b_wx), .writeLoc_y(b_wy), .write_flag(b_wf),
        .sweep_busy(b_busy), .sweep_done(b_done), .frame_count(b_frm), .overrun_count(b_ovr)
    );

    assign o_vx[0] = a_vx;   assign o_vx[1] = b_vx;
    assign o_vy[0] = a_vy;   assign o_vy[1] = b_vy;
    assign o_vv[0] = {1'b0, a_vv}; assign o_vv[1] = b_vv;
    assign o_wx[0] = a_wx;   assign o_wx[1] = b_wx;
    assign o_wy[0] = a_wy;   assign o_wy[1] = b_wy;
    assign o_wf[0] = {1'b0, a_wf}; assign o_wf[1] = b_wf;
    assign o_busy[0] = a_busy; assign o_busy[1] = b_busy;
    assign o_done[0] = a_done; assign o_done[1] = b_done;
    assign o_frm[0] = a_frm; assign o_frm[1] = b_frm;
    assign o_ovr[0] = a_ovr; assign o_ovr[1] = b_ovr;

    function automatic int p_xm(input int i); return (i == 0) ? 3 : 4; endfunction
    function automatic int p_ym(input int i); return (i == 0) ? 1 : 0; endfunction
    function automatic int p_ln(input int i); return (i == 0) ? 1 : 2; endfunction
    function automatic int p_lat(input int i); return (i == 0) ? 2 : 2; endfunction
    function automatic int p_g(input int i); return (p_xm(i) + p_ln(i)) / p_ln(i); endfunction
    function automatic int p_s(input int i); return p_g(i) * (p_ym(i) + 1); endfunction

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, i, obs, exp);
        end
    endtask

    // Group g of a sweep in raster order: base x, row y, live-lane mask
    task automatic grp(input int i, input int g, output int x, output int y, output int m);
        x = (g % p_g(i)) * p_ln(i);
        y = g / p_g(i);
        m = 0;
        for (int k = 0; k < p_ln(i); k++)
            if (x + k <= p_xm(i)) m = m | (1 << k);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            act[i] = 1'b0; d[i] = 0; frames[i] = 0; ovr[i] = 0;
        end
    endtask

    // Effect of the coming clock edge, from the inputs currently driven
    task automatic model_edge();
        bit trig, otick;
        int last;
        otick = run && (mode == 2'b00) && tick;
        trig  = otick || (run && (mode == 2'b10) && step_req);
        for (int i = 0; i < 2; i++) begin
            last = p_s(i) + p_lat(i);
            if (!act[i]) begin
                if (trig) begin act[i] = 1'b1; d[i] = 0; end
            end else if (!run) begin
                act[i] = 1'b0;
            end else if (d[i] == last) begin
                if (trig) d[i] = 0; else act[i] = 1'b0;
            end else begin
                if (otick && ovr[i] < 255) ovr[i]++;
                d[i]++;
                if (d[i] == last) frames[i]++;
            end
        end
    endtask

    task automatic check_all();
        int ev, ex, ey, ew, ewx, ewy, s, l;
        bit eb, ed;
        for (int i = 0; i < 2; i++) begin
            s = p_s(i); l = p_lat(i);
            ev = 0; ex = 0; ey = 0; ew = 0; ewx = 0; ewy = 0; eb = 1'b0; ed = 1'b0;
            if (act[i]) begin
                eb = 1'b1;
                if (d[i] < s) grp(i, d[i], ex, ey, ev);
                if (d[i] >= l && d[i] - l < s) grp(i, d[i] - l, ewx, ewy, ew);
                ed = (d[i] == s + l);
            end
            chk("view_valid", i, 32'(o_vv[i]), 32'(ev));
            chk("write_flag", i, 32'(o_wf[i]), 32'(ew));
            chk("sweep_busy", i, 32'(o_busy[i]), 32'(eb));
            chk("sweep_done", i, 32'(o_done[i]), 32'(ed));
            chk("overrun_count", i, 32'(o_ovr[i]), 32'(ovr[i]));
            if (!ed) chk("frame_count", i, 32'(o_frm[i]), 32'(frames[i] % 65536));
            if (!act[i] || ev != 0) begin
                chk("view_x", i, 32'(o_vx[i]), 32'(ex));
                chk("view_y", i, 32'(o_vy[i]), 32'(ey));
            end
            if (!act[i] || ew != 0) begin
                chk("write_x", i, 32'(o_wx[i]), 32'(ewx));
                chk("write_y", i, 32'(o_wy[i]), 32'(ewy));
            end
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; tick = 1'b0; mode = 2'b00; step_req = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all();
        rst = 1'b0;
        cycles(2);

        // First free-run sweep from a single game tick
        run = 1'b1;
        tick = 1'b1; cycle(); tick = 1'b0;
        chk("first_view_x", 0, 32'(a_vx), 32'd0);
        cycles(14);

        // Single-step mode: ticks ignored, one step gives one sweep, step while busy ignored
        mode = 2'b10;
        for (int k = 0; k < 5; k++) begin tick = 1'b1; cycle(); tick = 1'b0; cycle(); end
        step_req = 1'b1; cycle(); step_req = 1'b0;
        cycles(3);
        step_req = 1'b1; cycle(); step_req = 1'b0;
        cycles(12);
        chk("step_frames", 0, 32'(a_frm), 32'd2);

        // RUN dropped on the third view cycle, then restart
        mode = 2'b00;
        tick = 1'b1; cycle(); tick = 1'b0;
        cycle(); cycle();
        run = 1'b0; cycle();
        chk("abort_flag", 0, 32'(a_wf), 32'd0);
        run = 1'b1; cycles(3);
        tick = 1'b1; cycle(); tick = 1'b0;
        chk("restart_y", 0, 32'(a_vy), 32'd0);
        cycles(14);

        // Randomised traffic across modes, ticks, steps and occasional RUN drops
        for (int n = 0; n < 600; n++) begin
            tick     = ($urandom_range(0, 3) == 0);
            step_req = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            run      = ($urandom_range(0, 59) != 0);
            cycle();
        end
        tick = 1'b0; step_req = 1'b0; run = 1'b1; mode = 2'b00;
        cycles(15);

        // Game tick held high: overrun saturates while sweeps keep completing
        tick = 1'b1;
        cycles(700);
        chk("ovr_sat", 0, 32'(a_ovr), 32'd255);
        chk("ovr_sat", 1, 32'(b_ovr), 32'd255);
        tick = 1'b0;
        cycles(3);

        // Asynchronous reset between edges mid-sweep
        tick = 1'b1; cycles(2); tick = 1'b0;
        #2 rst = 1'b1;
        #1 model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
        cycles(4);
        tick = 1'b1; cycle(); tick = 1'b0;
        cycles(14);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
